// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matmul datapath and its result streamer.
package matmul_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_e;

  // Accumulator width wide enough for a K-term sum of DATA_WIDTH x DATA_WIDTH products.
  function automatic int unsigned acc_width(input int unsigned data_width,
                                            input int unsigned k);
    return 2 * data_width + $clog2(k);
  endfunction

endpackage

// File: rtl/matmul_result_streamer.sv
// Captures a full M x N result frame on done_in and streams it row-major over valid/ready.
module matmul_result_streamer
  import matmul_pkg::*;
#(
  parameter int unsigned M          = 6,
  parameter int unsigned N          = 6,
  parameter int unsigned K          = 6,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH, K)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done_in,
  input  logic [M*N*ACC_WIDTH-1:0]   C_flat,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [ACC_WIDTH-1:0]       m_data,
  output logic [$clog2(M):0]         m_row,
  output logic [$clog2(N):0]         m_col,
  output logic                       m_last,
  output logic                       busy,
  output logic                       overrun
);

  localparam int unsigned RW = $clog2(M) + 1;
  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned NE = M * N;
  localparam int unsigned IW = (NE > 1) ? $clog2(NE) : 1;

  stream_state_e         state_q, state_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [ACC_WIDTH-1:0]  data_q, data_d;
  logic                  last_q, last_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  load_c;
  logic                  fire_c;

  logic [ACC_WIDTH-1:0]  buf_q [NE];

  assign fire_c = (state_q == STREAM) && m_ready;

  // State register and registered stream outputs; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Frame buffer: one parallel load per accepted frame, never cleared.
  always_ff @(posedge clk) begin
    if (load_c) begin
      for (int i = 0; i < int'(NE); i++) begin
        buf_q[i] <= C_flat[i*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  // Next-state, index advance and next output values.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    idx_d     = idx_q;
    data_d    = data_q;
    last_d    = last_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    load_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (done_in) begin
          load_c  = 1'b1;
          state_d = STREAM;
          row_d   = '0;
          col_d   = '0;
          idx_d   = '0;
          data_d  = C_flat[ACC_WIDTH-1:0];
          last_d  = (NE == 1);
          valid_d = 1'b1;
        end
      end

      STREAM: begin
        if (fire_c && last_q) begin
          row_d = '0;
          col_d = '0;
          idx_d = '0;
          if (done_in) begin
            // Back-to-back frame: element (0,0) follows with no bubble.
            load_c  = 1'b1;
            data_d  = C_flat[ACC_WIDTH-1:0];
            last_d  = (NE == 1);
          end else begin
            state_d = IDLE;
            data_d  = '0;
            last_d  = 1'b0;
            valid_d = 1'b0;
          end
        end else begin
          if (fire_c) begin
            if (col_q == CW'(N - 1)) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
            idx_d  = idx_q + IW'(1);
            data_d = buf_q[idx_d];
            last_d = (row_d == RW'(M - 1)) && (col_d == CW'(N - 1));
          end
          // A frame arriving mid-stream has nowhere to go.
          if (done_in) begin
            overrun_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_row   = row_q;
  assign m_col   = col_q;
  assign m_last  = last_q;
  assign busy    = (state_q == STREAM);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Scoreboard bench for matmul_result_streamer with a 2x2 frame.
module tb_matmul_result_streamer;

  localparam int unsigned M  = 2;
  localparam int unsigned N  = 2;
  localparam int unsigned K  = 2;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 33;

  typedef struct packed {
    logic [AW-1:0] data;
    logic [1:0]    row;
    logic [1:0]    col;
    logic          last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              done_in;
  logic              m_ready;
  logic [M*N*AW-1:0] C_flat;
  logic              m_valid;
  logic [AW-1:0]     m_data;
  logic [1:0]        m_row;
  logic [1:0]        m_col;
  logic              m_last;
  logic              busy;
  logic              overrun;

  exp_t          exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [AW-1:0] f1 [4];
  logic [AW-1:0] f2 [4];
  logic [AW-1:0] f3 [4];

  matmul_result_streamer #(
    .M(M), .N(N), .K(K), .DATA_WIDTH(DW), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .done_in(done_in), .C_flat(C_flat),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_row(m_row), .m_col(m_col), .m_last(m_last),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Pops one expectation for every accepted element.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_xfer: got data %0h at (%0d,%0d) with nothing expected",
                   m_data, m_row, m_col);
        end else begin
          e = exp_q.pop_front();
          check("xfer", 64'({m_data, m_row, m_col, m_last}), 64'(e));
        end
      end
    end
  endtask

  // Called just after a posedge; done_in is sampled at the next edge.
  task automatic pulse(input logic [AW-1:0] v [4], input int n_push);
    done_in = 1'b1;
    C_flat  = {v[3], v[2], v[1], v[0]};
    for (int i = 0; i < n_push; i++) begin
      exp_q.push_back('{data: v[i], row: 2'(i / 2), col: 2'(i % 2), last: (i == 3)});
    end
    @(posedge clk); #1;
    done_in = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (m_valid && k < 20) begin
      step();
      k++;
    end
    check(name, 64'(m_valid), 64'(0));
    check({name, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    done_in = 1'b0;
    m_ready = 1'b1;
    C_flat  = '0;
    f1 = '{33'd1, 33'd2, 33'd3, 33'd4};
    f2 = '{33'd5, 33'd6, 33'd7, 33'd8};
    f3 = '{33'h1_0000_0001, 33'h1_FFFF_FFFF, 33'h0_0000_0000, 33'h0_8000_0000};
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'({m_valid, m_last, busy, overrun, m_row, m_col, m_data}), 64'(0));
    rst = 1'b0;
    step();

    // Basic stream with m_ready held high.
    pulse(f1, 4);
    check("capture_latency", 64'({m_valid, busy, m_data, m_row, m_col, m_last}),
          64'({1'b1, 1'b1, 33'd1, 2'd0, 2'd0, 1'b0}));
    repeat (3) step();
    check("last_at_t4", 64'({m_valid, m_last, m_data, m_row, m_col}),
          64'({1'b1, 1'b1, 33'd4, 2'd1, 2'd1}));
    step();
    check("valid_drop_t5", 64'({m_valid, busy, m_last}), 64'(0));
    wait_idle("basic_idle");

    // Backpressure on element 2 for two cycles.
    step();
    pulse(f1, 4);
    step();
    m_ready = 1'b0;
    check("bp_hold0", 64'({m_valid, m_data, m_row, m_col}), 64'({1'b1, 33'd2, 2'd0, 2'd1}));
    step();
    check("bp_hold1", 64'({m_valid, m_data, m_row, m_col}), 64'({1'b1, 33'd2, 2'd0, 2'd1}));
    step();
    check("bp_hold2", 64'({m_valid, m_data, m_row, m_col}), 64'({1'b1, 33'd2, 2'd0, 2'd1}));
    m_ready = 1'b1;
    wait_idle("bp_idle");

    // Frame arriving mid-stream is dropped and flags overrun.
    step();
    pulse(f1, 4);
    step();
    check("ovr_pre", 64'(overrun), 64'(0));
    done_in = 1'b1;
    C_flat  = {4{33'd9}};
    step();
    done_in = 1'b0;
    check("ovr_set", 64'(overrun), 64'(1));
    wait_idle("ovr_idle");
    check("ovr_sticky", 64'(overrun), 64'(1));

    // Reset after two transfers, with a coincident done_in that must lose.
    step();
    pulse(f1, 2);
    step();
    step();
    rst     = 1'b1;
    m_ready = 1'b0;
    done_in = 1'b1;
    step();
    rst     = 1'b0;
    done_in = 1'b0;
    check("rst_mid", 64'({m_valid, busy, overrun, m_row, m_col, m_last, m_data}), 64'(0));
    m_ready = 1'b1;
    step();
    wait_idle("rst_idle");

    // Restart from (0,0), then a back-to-back frame on the last handshake.
    pulse(f1, 4);
    check("restart", 64'({m_valid, m_data, m_row, m_col}), 64'({1'b1, 33'd1, 2'd0, 2'd0}));
    repeat (3) step();
    check("b2b_pre_last", 64'({m_valid, m_last, m_data}), 64'({1'b1, 1'b1, 33'd4}));
    pulse(f2, 4);
    check("b2b_first", 64'({m_valid, busy, m_data, m_row, m_col, overrun}),
          64'({1'b1, 1'b1, 33'd5, 2'd0, 2'd0, 1'b0}));
    wait_idle("b2b_idle");
    check("b2b_no_overrun", 64'(overrun), 64'(0));

    // Full-width values pass through unmodified.
    step();
    pulse(f3, 4);
    wait_idle("wide_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
